// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   EX -> MEM pipeline register built as a 2-entry skid buffer.  Each beat
//   carries the subtractor difference, condition flags computed when the beat
//   is accepted, the destination register and three control bits.
//
//   Handshake: a beat moves on an edge where valid && ready are both high.
//   Valid is never made to depend on ready, and once valid is high the
//   payload is held stable until the beat is taken.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   ex_valid / ex_ready      EX-side handshake (ex_ready is a flop output)
//   ex_a_msb, ex_b_msb       sign bits of subtractor operands A and B
//   ex_diff, ex_bout         subtractor difference and borrow-out
//   ex_rd, ex_ctl            destination register, {wb_en, mem_rd, mem_wr}
//   flush                    discard every held beat at the next edge
//   mem_valid / mem_ready    MEM-side handshake
//   mem_result, mem_flags    head difference and {Z, N, B, V}
//   mem_rd, mem_ctl          head destination register and control bits
//   stall_cnt                saturating count of MEM backpressure edges
//   dbg_state                current buffer state (0 EMPTY, 1 ONE, 2 TWO)
// ---------------------------------------------------------------------------
module ex_mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_a_msb,
   input  logic        ex_b_msb,
   input  logic [63:0] ex_diff,
   input  logic        ex_bout,
   input  logic [4:0]  ex_rd,
   input  logic [2:0]  ex_ctl,
   input  logic        flush,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [63:0] mem_result,
   output logic [3:0]  mem_flags,
   output logic [4:0]  mem_rd,
   output logic [2:0]  mem_ctl,
   output logic [15:0] stall_cnt,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   // Entry layout: {ctl[2:0], rd[4:0], flags[3:0], result[63:0]}
   localparam int ENTRY_W = 76;

   state_t               r_state;
   state_t               w_next_state;
   logic [ENTRY_W-1:0]   r_head;
   logic [ENTRY_W-1:0]   r_tail;
   logic                 r_ex_ready;
   logic [15:0]          r_stall_cnt;

   logic                 w_accept;
   logic                 w_pop;
   logic [3:0]           w_new_flags;
   logic [ENTRY_W-1:0]   w_new_entry;
   logic                 w_load_head;
   logic                 w_load_tail;
   logic                 w_promote;
   logic                 w_clear_head;
   logic                 w_clear_tail;

   assign w_accept = ex_valid && r_ex_ready;
   assign w_pop    = mem_valid && mem_ready;

   // Signed overflow of A - B: operands of opposite sign and a result whose
   // sign differs from A.
   assign w_new_flags = {(ex_diff == 64'd0),
                         ex_diff[63],
                         ex_bout,
                         (ex_a_msb != ex_b_msb) && (ex_diff[63] != ex_a_msb)};
   assign w_new_entry = {ex_ctl, ex_rd, w_new_flags, ex_diff};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and entry-update controls
   always_comb begin
      w_next_state = r_state;
      w_load_head  = 1'b0;
      w_load_tail  = 1'b0;
      w_promote    = 1'b0;
      w_clear_head = 1'b0;
      w_clear_tail = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_next_state = ST_ONE;
               w_load_head  = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_accept && !w_pop) begin
               w_next_state = ST_TWO;
               w_load_tail  = 1'b1;
            end else if (!w_accept && w_pop) begin
               w_next_state = ST_EMPTY;
               w_clear_head = 1'b1;
            end else if (w_accept && w_pop) begin
               // Head leaves and the new beat takes its place.
               w_load_head  = 1'b1;
            end
         end
         ST_TWO: begin
            // ex_ready is low here, so only a pop can happen.
            if (w_pop) begin
               w_next_state = ST_ONE;
               w_promote    = 1'b1;
               w_clear_tail = 1'b1;
            end
         end
         default: begin
            w_next_state = ST_EMPTY;
            w_clear_head = 1'b1;
            w_clear_tail = 1'b1;
         end
      endcase
      // Flush wins over any simultaneous accept or pop.
      if (flush) begin
         w_next_state = ST_EMPTY;
         w_load_head  = 1'b0;
         w_load_tail  = 1'b0;
         w_promote    = 1'b0;
         w_clear_head = 1'b1;
         w_clear_tail = 1'b1;
      end
   end

   // Entry storage; emptied entries are zeroed so idle outputs read as 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_clear_head) begin
            r_head <= '0;
         end else if (w_promote) begin
            r_head <= r_tail;
         end else if (w_load_head) begin
            r_head <= w_new_entry;
         end

         if (w_clear_tail) begin
            r_tail <= '0;
         end else if (w_load_tail) begin
            r_tail <= w_new_entry;
         end
      end
   end

   // ex_ready is taken from the next state so it is a clean flop output with
   // no path from mem_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_ready <= 1'b1;
      end else begin
         r_ex_ready <= (w_next_state != ST_TWO);
      end
   end

   // Backpressure counter; deliberately ignores flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= 16'd0;
      end else if (mem_valid && !mem_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign ex_ready   = r_ex_ready;
   assign mem_valid  = (r_state != ST_EMPTY);
   assign mem_result = r_head[63:0];
   assign mem_flags  = r_head[67:64];
   assign mem_rd     = r_head[72:68];
   assign mem_ctl    = r_head[75:73];
   assign stall_cnt  = r_stall_cnt;
   assign dbg_state  = r_state;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL provide a single clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 ex_valid  in  1  EX beat present.
REQ-005 ex_ready  out  1  stage can accept a beat.
REQ-006 ex_a_msb, ex_b_msb  in  1 each  sign bits of the subtractor operands A and B.
REQ-007 ex_diff  in  64  subtractor Diff.
REQ-008 ex_bout  in  1  subtractor Bout.
REQ-009 ex_rd  in  5  destination register.
REQ-010 ex_ctl  in  3  {wb_en, mem_rd, mem_wr}.
REQ-011 flush  in  1  discard all held beats.
REQ-012 mem_valid  out  1  MEM beat present.
REQ-013 mem_ready  in  1  MEM accepts the beat.
REQ-014 mem_result  out  64  registered difference.
REQ-015 mem_flags  out  4  {Z, N, B, V}.
REQ-016 mem_rd  out  5  destination register; mem_ctl  out  3  control bits.
REQ-017 stall_cnt  out  16  count of MEM backpressure cycles.

Function
REQ-018 SHALL act as a 2-entry skid buffer with states EMPTY, ONE and TWO; mem_* outputs SHALL present the head entry.
REQ-019 Accept = ex_valid && ex_ready; pop = mem_valid && mem_ready; both SHALL be evaluated on the same edge.
REQ-020 EMPTY: on accept, go to ONE.
REQ-021 ONE: accept without pop -> TWO; pop without accept -> EMPTY; accept with pop -> stay in ONE, head replaced by the new beat.
REQ-022 TWO: on pop, go to ONE with the second entry promoted to head; no accept is possible in TWO.
REQ-023 ex_ready SHALL be a registered output, deasserted only in state TWO; it SHALL have no combinational path from mem_ready.
REQ-024 mem_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-025 Flags SHALL be computed at accept time and stored with the beat:
  - Z = (ex_diff == 0)
  - N = ex_diff[63]
  - B = ex_bout
  - V = (ex_a_msb != ex_b_msb) && (ex_diff[63] != ex_a_msb)
REQ-026 Latency SHALL be 1 cycle: a beat accepted at edge k SHALL appear on mem_* after edge k when the buffer was EMPTY or popping.
REQ-027 Beat order SHALL be preserved, with no loss or duplication.
REQ-028 Held outputs SHALL remain stable while mem_valid && !mem_ready.
REQ-029 Flush SHALL force EMPTY at the next edge, clearing both entries. It SHALL override a simultaneous accept and pop; the beat offered on that edge is dropped.
REQ-030 On flush, ex_ready SHALL be 1 in the following cycle.
REQ-031 stall_cnt SHALL increment on each edge where mem_valid && !mem_ready, saturate at 0xFFFF, and be unaffected by flush.
REQ-032 Emptied entries SHALL zero their data and control fields, so mem_ctl = 0 whenever mem_valid = 0.

Reset
REQ-033 While rst is high, the block SHALL be held asynchronously in EMPTY.
REQ-034 Reset values SHALL be: mem_valid=0, ex_ready=1, mem_result=0, mem_flags=0, mem_rd=0, mem_ctl=0, stall_cnt=0.
REQ-035 Reset asserted mid-transfer SHALL discard all entries; no beat SHALL emerge after reset is released.

Verification
REQ-036 Single beat: ex_diff=0, bout=0, a_msb=b_msb=0, rd=5, mem_ready=1 -> one cycle later mem_valid=1, flags=1000, mem_rd=5.
REQ-037 Overflow: a_msb=0, b_msb=1, ex_diff=0x8000_0000_0000_0000, bout=1 -> flags=0111.
REQ-038 Backpressure: mem_ready=0 and beats D1,D2,D3 offered -> D1,D2 held, ex_ready=0, D3 stalls; mem_ready=1 -> outputs D1, D2, D3 in order; stall_cnt equals the number of held cycles.
REQ-039 Flush: in state TWO, assert flush with ex_valid=1 -> next cycle mem_valid=0, ex_ready=1, offered beat absent.
REQ-040 Streaming: ex_valid=mem_ready=1 for 100 cycles with incrementing ex_diff -> 100 beats in order, ex_ready never drops.
REQ-041 Reset: assert rst asynchronously while in state TWO -> outputs immediately take their REQ-034 values.
